// File: rtl/reset_sequencer.sv
// reset_sequencer: holds reset domains until PLL lock is stable, then releases them in order.
// Lock loss, a debounced button press or a software request re-asserts every domain.
module reset_sequencer #(
  parameter int N_OUT       = 2,
  parameter int HOLD_CYCLES = 2**24,
  parameter int STAGE_GAP   = 1024,
  parameter int DEB_CYCLES  = 65536
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pll_lock,
  input  logic             i_btn,
  input  logic             i_sw_req,
  output logic [N_OUT-1:0] o_rst,
  output logic             o_ready,
  output logic [1:0]       o_cause
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = STAGE_GAP   > 1 ? $clog2(STAGE_GAP)   : 1;
  localparam int DW = DEB_CYCLES  > 1 ? $clog2(DEB_CYCLES)  : 1;
  localparam int SW = N_OUT       > 1 ? $clog2(N_OUT)       : 1;

  typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;

  state_t        r_state;
  logic          r_lock_m, r_lock_s, r_btn_m, r_btn_s, r_btn_d;
  logic [DW-1:0] r_deb_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [SW-1:0] r_stage;
  logic          w_good, w_trig;
  logic [1:0]    w_cause;
  logic [SW-1:0] w_next;

  assign w_good  = r_lock_s & ~r_btn_d;
  assign w_trig  = ~r_lock_s | r_btn_d | i_sw_req;
  // lock loss outranks button, button outranks software
  assign w_cause = ~r_lock_s ? 2'b01 : r_btn_d ? 2'b10 : 2'b11;
  assign w_next  = r_stage + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_ASSERT;
      o_rst      <= '1;
      o_ready    <= 1'b0;
      o_cause    <= 2'b00;
      r_lock_m   <= 1'b0;
      r_lock_s   <= 1'b0;
      r_btn_m    <= 1'b0;
      r_btn_s    <= 1'b0;
      r_btn_d    <= 1'b0;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_stage    <= '0;
    end else begin
      r_lock_m <= i_pll_lock;
      r_lock_s <= r_lock_m;
      r_btn_m  <= i_btn;
      r_btn_s  <= r_btn_m;
      if (r_btn_s == r_btn_d) r_deb_cnt <= '0;
      else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
        r_btn_d   <= r_btn_s;
        r_deb_cnt <= '0;
      end else r_deb_cnt <= r_deb_cnt + 1'b1;
      if (r_state != S_ASSERT && w_trig) begin
        r_state    <= S_ASSERT;
        o_rst      <= '1;
        o_ready    <= 1'b0;
        o_cause    <= w_cause;
        r_hold_cnt <= '0;
        r_gap_cnt  <= '0;
        r_stage    <= '0;
      end else if (r_state == S_ASSERT) begin
        if (!w_good) r_hold_cnt <= '0;
        else if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          o_rst[0]   <= 1'b0;
          r_stage    <= '0;
          r_gap_cnt  <= '0;
          r_hold_cnt <= '0;
          o_ready    <= N_OUT == 1;
          r_state    <= N_OUT == 1 ? S_RUN : S_RELEASE;
        end else r_hold_cnt <= r_hold_cnt + 1'b1;
      end else if (r_state == S_RELEASE) begin
        if (r_gap_cnt == GW'(STAGE_GAP - 1)) begin
          r_gap_cnt     <= '0;
          r_stage       <= w_next;
          o_rst[w_next] <= 1'b0;
          if (w_next == SW'(N_OUT - 1)) begin
            o_ready <= 1'b1;
            r_state <= S_RUN;
          end
        end else r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end
endmodule
